// File: rtl/rv_pkg.sv
// Shared RV32I control types: opcodes, instruction classes, datapath selects, FSM states.
package rv_pkg;

    localparam int unsigned OPC_W = 7;

    // Base RV32I major opcodes (instruction bits [6:0])
    typedef enum logic [OPC_W-1:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    // Instruction class as seen by the control sequencer
    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_FENCE,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'd0,
        ALU_OP_FUNCT  = 2'd1,
        ALU_OP_BRANCH = 2'd2
    } alu_op_e;

    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } ctrl_state_t;

endpackage

// File: rtl/rv_op_class.sv
// Combinational opcode classifier shared by the multicycle and pipelined decoders.
module rv_op_class
    import rv_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_e        class_o,
    output logic             legal_o
);

    // Map the major opcode onto an instruction class
    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_OP:       class_o = CLS_R;
            OP_IMM:      class_o = CLS_I;
            OP_LOAD:     class_o = CLS_LOAD;
            OP_STORE:    class_o = CLS_STORE;
            OP_BRANCH:   class_o = CLS_BRANCH;
            OP_JAL:      class_o = CLS_JAL;
            OP_JALR:     class_o = CLS_JALR;
            OP_LUI:      class_o = CLS_LUI;
            OP_AUIPC:    class_o = CLS_AUIPC;
            OP_MISC_MEM: class_o = CLS_FENCE;
            OP_SYSTEM:   class_o = CLS_SYSTEM;
            default:     class_o = CLS_ILLEGAL;
        endcase
    end

    assign legal_o = (class_o != CLS_ILLEGAL);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback strobes.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ir,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WDOG_W = 32;

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              retire_c;
    logic              mem_wait_c;
    logic              wdog_expire_c;
    op_class_e         cls;
    logic              cls_legal;
    logic              unused_ir;

    rv_op_class u_op_class (
        .opcode_i (ir[6:0]),
        .class_o  (cls),
        .legal_o  (cls_legal)
    );

    // Operand/function fields of the IR are consumed by the datapath, not here
    assign unused_ir = ^ir[31:7];

    // State, retire counter, watchdog and sticky halt causes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            wdog_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            wdog_q    <= wdog_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Memory watchdog: counts consecutive not-ready cycles; any other cycle clears it
    always_comb begin
        mem_wait_c    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
        wdog_d        = '0;
        wdog_expire_c = 1'b0;
        if ((MEM_TIMEOUT != 0) && mem_wait_c) begin
            wdog_d        = wdog_q + WDOG_W'(1);
            wdog_expire_c = (wdog_d == WDOG_W'(MEM_TIMEOUT));
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        retire_c     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = ALU_B_RS2;
        alu_op_sel   = ALU_OP_ADD;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wdog_expire_c) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end

            S_DECODE: begin
                if (cls == CLS_SYSTEM) begin
                    state_d = S_HALT;
                end else if (!cls_legal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (cls)
                    CLS_R:                alu_op_sel = ALU_OP_FUNCT;
                    CLS_I: begin
                        alu_b_sel  = ALU_B_IMM;
                        alu_op_sel = ALU_OP_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE,
                    CLS_JALR:             alu_b_sel = ALU_B_IMM;
                    CLS_LUI: begin
                        alu_a_sel = ALU_A_ZERO;
                        alu_b_sel = ALU_B_IMM;
                    end
                    CLS_AUIPC, CLS_JAL: begin
                        alu_a_sel = ALU_A_PC;
                        alu_b_sel = ALU_B_IMM;
                    end
                    CLS_BRANCH:           alu_op_sel = ALU_OP_BRANCH;
                    default: ;
                endcase
                case (cls)
                    CLS_BRANCH: begin
                        pc_we    = 1'b1;
                        pc_sel   = br_taken ? PC_IMM : PC_PLUS4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    CLS_FENCE: begin
                        pc_we    = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    default:             state_d = S_WB;
                endcase
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_we    = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wdog_expire_c) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
            end

            S_WB: begin
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
                // Jumps keep their EXEC operands so the link/target values stay stable
                case (cls)
                    CLS_LOAD: wb_sel = WB_MEM;
                    CLS_JAL: begin
                        wb_sel    = WB_PC4;
                        pc_sel    = PC_IMM;
                        alu_a_sel = ALU_A_PC;
                        alu_b_sel = ALU_B_IMM;
                    end
                    CLS_JALR: begin
                        wb_sel    = WB_PC4;
                        pc_sel    = PC_ALU;
                        alu_b_sel = ALU_B_IMM;
                    end
                    default: ;
                endcase
            end

            S_HALT: ;

            default: state_d = S_FETCH;
        endcase
    end

    assign retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;

    assign retired = retired_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: per-instruction cycle-trace model plus literal spot checks.
module tb_rv_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      ir;
    logic             br_taken;
    logic             mem_ready;
    logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]       pc_sel, alu_a_sel, alu_op_sel, wb_sel;
    logic             alu_b_sel, rf_we, halted, illegal, bus_err;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir           (ir),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op_sel   (alu_op_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .retired      (retired)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] alu_a;
        logic       alu_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       halted;
        logic       illegal;
        logic       bus_err;
        logic [3:0] retired;
    } obs_t;

    typedef struct {
        string       nm;
        logic [31:0] got;
        logic [31:0] want;
    } lit_t;

    obs_t  got;
    obs_t  exp_r;
    logic  exp_en = 1'b0;
    string exp_nm;
    lit_t  lit_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Model state: retired count and sticky halt status
    int m_ret;
    bit m_halt, m_ill, m_bus;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5;
    localparam int K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_FENCE = 9, K_SYS = 10, K_BAD = 11;

    assign got = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel,
                  alu_b_sel, alu_op_sel, rf_we, wb_sel, halted, illegal, bus_err, retired};

    // Single checker: literal spot checks and the per-cycle trace comparison
    always @(negedge clk) begin
        while (lit_q.size() > 0) begin
            lit_t l;
            l = lit_q.pop_front();
            n_vec++;
            if (l.got !== l.want) begin
                n_err++;
                $display("FAIL %s: got %0h, expected %0h", l.nm, l.got, l.want);
            end
        end
        if (exp_en) begin
            n_vec++;
            if (got !== exp_r) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", exp_nm, got, exp_r);
            end
        end
    end

    function automatic int kind(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b0001111: return K_FENCE;
            7'b1110011: return K_SYS;
            default:    return K_BAD;
        endcase
    endfunction

    // Everything idle except the sticky status the model currently holds
    function automatic obs_t blank();
        obs_t e;
        e         = '0;
        e.halted  = m_halt;
        e.illegal = m_ill;
        e.bus_err = m_bus;
        e.retired = 4'(m_ret % 16);
        return e;
    endfunction

    // ALU operand selection table: a 0=rs1 1=PC 2=zero, b 0=rs2 1=imm, op 0=ADD 1=funct 2=branch
    function automatic obs_t with_ops(input int k, input obs_t e_in);
        obs_t e;
        e = e_in;
        case (k)
            K_R:           e.alu_op = 2'd1;
            K_I:           begin e.alu_b = 1'b1; e.alu_op = 2'd1; end
            K_LD, K_ST:    e.alu_b = 1'b1;
            K_LUI:         begin e.alu_a = 2'd2; e.alu_b = 1'b1; end
            K_AUIPC, K_JAL: begin e.alu_a = 2'd1; e.alu_b = 1'b1; end
            K_JALR:        e.alu_b = 1'b1;
            K_BR:          e.alu_op = 2'd2;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_lit(input string nm, input logic [31:0] g, input logic [31:0] w);
        lit_t l;
        l.nm   = nm;
        l.got  = g;
        l.want = w;
        lit_q.push_back(l);
    endtask

    // One clock: drive inputs, publish the expectation, advance to just past the edge
    task automatic step(input logic rdy, input logic br, input obs_t e, input string nm);
        mem_ready = rdy;
        br_taken  = br;
        exp_r     = e;
        exp_nm    = nm;
        exp_en    = 1'b1;
        @(posedge clk);
        #1;
        exp_en    = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        exp_en    = 1'b0;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        br_taken  = 1'b0;
        m_ret     = 0;
        m_halt    = 1'b0;
        m_ill     = 1'b0;
        m_bus     = 1'b0;
        #2;
        check_lit({nm, " mem_req"}, 32'(mem_req), 32'd1);
        check_lit({nm, " ir_we"},   32'(ir_we),   32'd0);
        check_lit({nm, " pc_we"},   32'(pc_we),   32'd0);
        check_lit({nm, " rf_we"},   32'(rf_we),   32'd0);
        check_lit({nm, " halted"},  32'(halted),  32'd0);
        check_lit({nm, " illegal"}, 32'(illegal), 32'd0);
        check_lit({nm, " bus_err"}, 32'(bus_err), 32'd0);
        check_lit({nm, " retired"}, 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Walk one instruction through its expected cycles; fw/mw are not-ready cycles before ready
    task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                             input logic br, input string nm);
        int   k;
        obs_t e;
        k  = kind(instr[6:0]);
        ir = instr;
        for (int i = 0; i <= fw; i++) begin
            e         = blank();
            e.mem_req = 1'b1;
            e.ir_we   = (i == fw);
            step(i == fw, br, e, {nm, " fetch"});
            if (i < fw && i + 1 == int'(TO)) begin
                m_halt = 1'b1;
                m_bus  = 1'b1;
                return;
            end
        end
        step(1'b1, br, blank(), {nm, " decode"});
        if (k == K_SYS) begin
            m_halt = 1'b1;
            return;
        end
        if (k == K_BAD) begin
            m_halt = 1'b1;
            m_ill  = 1'b1;
            return;
        end
        e = with_ops(k, blank());
        if (k == K_BR) begin
            e.pc_we  = 1'b1;
            e.pc_sel = br ? 2'd1 : 2'd0;
        end
        if (k == K_FENCE) e.pc_we = 1'b1;
        step(1'b1, br, e, {nm, " exec"});
        if (k == K_BR || k == K_FENCE) begin
            m_ret++;
            return;
        end
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= mw; i++) begin
                e              = blank();
                e.mem_req      = 1'b1;
                e.mem_addr_sel = 1'b1;
                e.mem_we       = (k == K_ST);
                e.pc_we        = (k == K_ST) && (i == mw);
                step(i == mw, br, e, {nm, " mem"});
                if (i < mw && i + 1 == int'(TO)) begin
                    m_halt = 1'b1;
                    m_bus  = 1'b1;
                    return;
                end
            end
            if (k == K_ST) begin
                m_ret++;
                return;
            end
        end
        e       = blank();
        e.rf_we = 1'b1;
        e.pc_we = 1'b1;
        if (k == K_LD) e.wb_sel = 2'd1;
        if (k == K_JAL) begin
            e        = with_ops(k, e);
            e.wb_sel = 2'd2;
            e.pc_sel = 2'd1;
        end
        if (k == K_JALR) begin
            e        = with_ops(k, e);
            e.wb_sel = 2'd2;
            e.pc_sel = 2'd2;
        end
        step(1'b1, br, e, {nm, " wb"});
        m_ret++;
    endtask

    // Halted cycles with mem_ready toggling: nothing may move
    task automatic halt_hold(input int n, input string nm);
        for (int i = 0; i < n; i++) step((i % 2) == 0, 1'b1, blank(), nm);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b1;
        ir        = 32'h0;
        br_taken  = 1'b0;
        mem_ready = 1'b0;
        #1;
        do_reset("reset");

        run_instr(32'h00500093, 0, 0, 1'b1, "addi");
        check_lit("addi retired", 32'(retired), 32'd1);
        run_instr(32'h0000A103, 0, 3, 1'b0, "lw_wait3");
        check_lit("lw retired", 32'(retired), 32'd2);
        run_instr(32'h00208463, 0, 0, 1'b1, "beq_taken");
        run_instr(32'h00208463, 0, 0, 1'b0, "beq_not");
        check_lit("beq retired", 32'(retired), 32'd4);
        run_instr(32'h0020A023, 0, 1, 1'b0, "sw");
        run_instr(32'h002081B3, 0, 0, 1'b1, "add");
        run_instr(32'h123450B7, 0, 0, 1'b0, "lui");
        run_instr(32'h00001097, 0, 0, 1'b0, "auipc");
        run_instr(32'h008000EF, 0, 0, 1'b0, "jal");
        run_instr(32'h000080E7, 0, 0, 1'b1, "jalr");
        check_lit("mix retired", 32'(retired), 32'd10);

        run_instr(32'h0000007F, 0, 0, 1'b0, "illegal");
        check_lit("illegal flag", 32'(illegal), 32'd1);
        check_lit("illegal halted", 32'(halted), 32'd1);
        halt_hold(4, "illegal hold");
        check_lit("illegal hold mem_req", 32'(mem_req), 32'd0);
        do_reset("reset_mid_halt");

        run_instr(32'h00000073, 0, 0, 1'b0, "ecall");
        check_lit("ecall halted", 32'(halted), 32'd1);
        check_lit("ecall illegal", 32'(illegal), 32'd0);
        halt_hold(2, "ecall hold");
        do_reset("reset_ecall");

        run_instr(32'h00500093, 4, 0, 1'b0, "fetch_timeout");
        check_lit("fetch_timeout bus_err", 32'(bus_err), 32'd1);
        halt_hold(2, "bus_err hold");
        do_reset("reset_bus_err");
        run_instr(32'h00500093, 3, 0, 1'b0, "fetch_ready_last");
        check_lit("fetch_ready_last bus_err", 32'(bus_err), 32'd0);
        check_lit("fetch_ready_last retired", 32'(retired), 32'd1);
        run_instr(32'h0000A103, 0, 4, 1'b0, "mem_timeout");
        check_lit("mem_timeout bus_err", 32'(bus_err), 32'd1);
        do_reset("reset_fence");

        for (int i = 0; i < 16; i++) begin
            run_instr(32'h0000000F, 0, 0, 1'b0, "fence");
            if (i == 14) check_lit("fence retired 15", 32'(retired), 32'd15);
        end
        check_lit("fence retired wrap", 32'(retired), 32'd0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
